token_launch_ctrl: RTL
======================

# token_launch_ctrl

Token launcher and return monitor for the FIR tap-token ring. It injects a single one-cycle token into the first get-token stage of the ring and tracks the token's position as a tap index. It checks that the token comes back from the last stage after exactly TAPS enabled cycles, then reports completion or a lost/duplicated-token error. It sits between the FIR sequencer (start/done) and the head/tail of the token register chain.

## Interface
- TAPS, 8: number of token stages in the ring (≥2); round-trip latency in enabled cycles.
- CW, $clog2(TAPS+1): width of the hop counter and tap_sel.

- clk  input  1  rising-edge clock, single domain.
- init  input  1  synchronous, active-high reset; takes effect regardless of enable.
- enable  input  1  clock-enable; when low all state holds and tok_out is forced 0.
- start  input  1  request a token round; sampled only in IDLE with enable high.
- tok_ret  input  1  token arriving from the tail stage of the ring.
- tok_out  output  1  token driven into the head stage.
- tap_sel  output  CW  current token position, 0..TAPS-1; 0 when not circulating.
- busy  output  1  high in LAUNCH and CIRC.
- done  output  1  one-cycle pulse on a correct return.
- err  output  1  sticky error flag.

## Operation
- States:
  - IDLE: waits for start.
  - LAUNCH: tok_out=1, hop=0.
  - CIRC: token in flight, hop counts up.
  - DONE: done=1 for one cycle.
  - ERR: err held, waits for start or init.
- Transitions, all gated by enable:
  - IDLE, start → LAUNCH.
  - LAUNCH → CIRC, hop←1.
  - CIRC, tok_ret=0 and hop<TAPS → CIRC, hop←hop+1.
  - CIRC, tok_ret=1 and hop==TAPS → DONE.
  - CIRC, tok_ret=1 and hop<TAPS (early or duplicate) → ERR.
  - CIRC, hop==TAPS and tok_ret=0 (lost) → ERR.
  - DONE → IDLE.
  - ERR, start → LAUNCH with err cleared.
- tok_ret seen in IDLE, LAUNCH, DONE or ERR: spurious token; set err, state unchanged (IDLE goes to ERR).
- tap_sel = hop-1 in CIRC, 0 in LAUNCH and elsewhere. It never reaches TAPS: it saturates at TAPS-1 on the hop==TAPS cycle.
- start while busy, in DONE, or with enable low: ignored, not queued.
- Hop counter arithmetic is unsigned CW-bit. No wrap is possible because the counter is compared against TAPS before increment.

## Timing
- Reset (init=1 at an edge): next cycle state=IDLE, hop=0. Outputs: tok_out=0, tap_sel=0, busy=0, done=0, err=0. init mid-round abandons the round with no done or err. The ring stages are re-initialised by the same init.
- start accepted at edge k → tok_out=1 during cycle k+1 (exactly one enabled cycle).
- Correct tok_ret is expected in the cycle TAPS enabled cycles after tok_out. done pulses in the following cycle, and busy falls in the same cycle done rises.
- Launch-to-done latency = TAPS+2 enabled cycles. Back-to-back rounds: next start accepted in IDLE, so minimum period = TAPS+3.
- Cycles with enable=0 are invisible. They stretch latency but do not advance hop or cause errors. done and tok_out are masked to 0 while enable=0, and done is re-presented when enable returns.
- err rises in the cycle after the offending edge and stays high until init or an accepted start.

## Configuration
- TOKEN_REARM_EN defined: DONE goes directly to LAUNCH instead of IDLE. The token recirculates continuously with period TAPS+2, and done pulses each lap. Deasserting start (level-sampled in DONE) returns to IDLE.
- Not defined: one round per start, as above; start level in DONE is ignored.

## Test plan
- TAPS=8, init then start at cycle 2 → tok_out=1 at cycle 3; tok_ret looped via 8-stage ring returns at cycle 11; done=1 at cycle 12, err=0, tap_sel ran 0..7.
- Same setup, ring tail forced 0 → err=1 at cycle 12, done never asserts, state ERR; start then clears err and relaunches.
- Inject extra tok_ret pulse at hop 4 → err=1 the next cycle; spurious tok_ret in IDLE → err=1.
- enable toggled 0 for 3 cycles mid-round → done delayed by exactly 3 cycles, tok_out=0 while enable=0, no err.
- init asserted at hop 5 → next cycle all outputs 0, IDLE; stale tok_ret does not appear because the ring is also initialised.
- TOKEN_REARM_EN with start held high → done pulses every 10 cycles; drop start → returns to IDLE after the next done.

Source files
------------

// File: rtl/token_launch_ctrl_if.sv
// token_launch_ctrl_if: sequencer/ring-side signals of the token launcher
//   enable, start, tok_ret : driven by master (sequencer + ring tail)
//   tok_out, tap_sel, busy, done, err : driven by slave (token_launch_ctrl)
interface token_launch_ctrl_if #(parameter int CW = 4);
  logic          enable;
  logic          start;
  logic          tok_ret;
  logic          tok_out;
  logic [CW-1:0] tap_sel;
  logic          busy;
  logic          done;
  logic          err;
  modport master (output enable, start, tok_ret, input tok_out, tap_sel, busy, done, err);
  modport slave  (input enable, start, tok_ret, output tok_out, tap_sel, busy, done, err);
endinterface

// File: rtl/token_launch_ctrl.sv
// token_launch_ctrl: launches one token into the FIR tap ring and checks its return after TAPS hops
//   clk, init (sync active-high reset, ignores enable)
//   bus.enable/start/tok_ret in; bus.tok_out/tap_sel/busy/done/err out
//   TOKEN_REARM_EN: DONE relaunches directly while start is held high
module token_launch_ctrl #(
  parameter int TAPS = 8,
  parameter int CW   = $clog2(TAPS + 1)
) (
  input logic               clk,
  input logic               init,
  token_launch_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LAUNCH, CIRC, DONE, ERR} state_t;
  localparam logic [CW-1:0] TAPS_W = CW'(TAPS);
  state_t        state, state_n;
  logic [CW-1:0] hop, hop_n;
  logic          err_q, err_n;
  always_ff @(posedge clk) begin
    if (init) begin
      state <= IDLE;
      hop   <= '0;
      err_q <= 1'b0;
    end else if (bus.enable) begin
      state <= state_n;
      hop   <= hop_n;
      err_q <= err_n;
    end
  end
  // A returning token outside CIRC is spurious: it raises err and blocks a launch in the same cycle.
  always_comb begin
    state_n = state;
    hop_n   = hop;
    err_n   = err_q;
    case (state)
      IDLE, ERR: begin
        if (bus.tok_ret) begin
          state_n = ERR;
          err_n   = 1'b1;
        end else if (bus.start) begin
          state_n = LAUNCH;
          err_n   = 1'b0;
        end
      end
      LAUNCH: begin
        state_n = CIRC;
        hop_n   = CW'(1);
        err_n   = err_q | bus.tok_ret;
      end
      CIRC: begin
        if (hop == TAPS_W) begin
          state_n = bus.tok_ret ? DONE : ERR;
          hop_n   = '0;
          err_n   = err_q | ~bus.tok_ret;
        end else if (bus.tok_ret) begin
          state_n = ERR;
          hop_n   = '0;
          err_n   = 1'b1;
        end else begin
          hop_n   = hop + CW'(1);
        end
      end
      DONE: begin
`ifdef TOKEN_REARM_EN
        state_n = bus.start ? LAUNCH : IDLE;
        err_n   = (err_q & ~bus.start) | bus.tok_ret;
`else
        state_n = IDLE;
        err_n   = err_q | bus.tok_ret;
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  assign bus.tok_out = bus.enable && state == LAUNCH;
  assign bus.done    = bus.enable && state == DONE;
  assign bus.busy    = state == LAUNCH || state == CIRC;
  assign bus.err     = err_q;
  // hop is TAPS on the last CIRC cycle, so hop-1 tops out at TAPS-1
  assign bus.tap_sel = state == CIRC ? hop - CW'(1) : '0;
endmodule
